// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with a small prefetch queue between imem and decode.
// Optional macro FETCH_HALT_DETECT_EN stops fetching after an opcode whose top five bits are zero.
module fetch_queue_stage #(
    parameter int                 DATA_W    = 16,
    parameter int                 DEPTH     = 4,
    parameter logic [DATA_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(16'h0800)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halt,
    input  logic                       stall,
    input  logic                       doBranch,
    input  logic [DATA_W-1:0]          branchPc,
    output logic [DATA_W-1:0]          imemAddr,
    output logic                       imemEn,
    input  logic [DATA_W-1:0]          imemData,
    output logic [DATA_W-1:0]          instr,
    output logic [DATA_W-1:0]          nextPc,
    output logic                       instrValid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] next_pc_q, next_pc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              fetch_halted_q, fetch_halted_d;

    logic [DATA_W-1:0] q_instr_q [DEPTH];
    logic [DATA_W-1:0] q_pc_q    [DEPTH];

    logic valid_s, pop_s, accept_s, push_s;

    // Handshake: a pop frees a slot in the same cycle, so a full queue can still accept a push.
    always_comb begin
        valid_s  = (count_q != '0) && !doBranch;
        pop_s    = valid_s && !stall;
        accept_s = (count_q < DEPTH_C) || pop_s;
        push_s   = !rst && !halt && !doBranch && !fetch_halted_q && accept_s;
    end

    // Next-state logic; a branch overrides every other activity in the cycle.
    always_comb begin
        pc_d           = pc_q;
        next_pc_d      = next_pc_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        fetch_halted_d = fetch_halted_q;
        if (doBranch) begin
            pc_d           = branchPc;
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            count_d        = '0;
            fetch_halted_d = 1'b0;
        end else begin
            pc_d      = push_s ? pc_q + DATA_W'(2) : pc_q;
            wr_ptr_d  = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d  = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
            next_pc_d = pop_s ? q_pc_q[rd_ptr_q] : next_pc_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
`ifdef FETCH_HALT_DETECT_EN
            if (push_s && (imemData[DATA_W-1 -: 5] == 5'b00000)) begin
                fetch_halted_d = 1'b1;
            end else begin
                fetch_halted_d = fetch_halted_q;
            end
`else
            fetch_halted_d = 1'b0;
`endif
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            next_pc_q      <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            fetch_halted_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            next_pc_q      <= next_pc_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            fetch_halted_q <= fetch_halted_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_instr_q[wr_ptr_q] <= imemData;
            q_pc_q[wr_ptr_q]    <= pc_q + DATA_W'(2);
        end
    end

    assign imemAddr   = pc_q;
    assign imemEn     = push_s;
    assign instrValid = valid_s;
    assign instr      = valid_s ? q_instr_q[rd_ptr_q] : NOP_INSTR;
    assign nextPc     = valid_s ? q_pc_q[rd_ptr_q] : next_pc_q;
    assign count      = count_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed self-checking bench for fetch_queue_stage (DATA_W=16, DEPTH=4).
// Memory model returns 16'h1000+addr, optionally 16'h0000 at address 6.
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        rst, halt, stall, doBranch;
    logic [15:0] branchPc, imemAddr, imemData, instr, nextPc;
    logic        imemEn, instrValid;
    logic [2:0]  count;
    logic        zero6;
    int          tests = 0;
    int          fails = 0;

    fetch_queue_stage dut (
        .clk(clk), .rst(rst), .halt(halt), .stall(stall), .doBranch(doBranch),
        .branchPc(branchPc), .imemAddr(imemAddr), .imemEn(imemEn), .imemData(imemData),
        .instr(instr), .nextPc(nextPc), .instrValid(instrValid), .count(count)
    );

    always #5 clk = ~clk;

    assign imemData = (zero6 && imemAddr == 16'h0006) ? 16'h0000 : 16'h1000 + imemAddr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt = 1'b0; stall = 1'b0; doBranch = 1'b0; branchPc = 16'h0000; zero6 = 1'b0;
        tick(); tick(); #1;
        tests++; if (imemEn !== 1'b0) begin fails++; $display("FAIL rst_imemEn got %b want 0", imemEn); end
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", instrValid); end
        tests++; if (instr !== 16'h0800) begin fails++; $display("FAIL rst_instr got %h want 0800", instr); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
        tests++; if (nextPc !== 16'h0000) begin fails++; $display("FAIL rst_nextPc got %h want 0000", nextPc); end
        tests++; if (imemAddr !== 16'h0000) begin fails++; $display("FAIL rst_addr got %h want 0000", imemAddr); end
    endtask

    task automatic test_fetch();
        logic [15:0] exp_i [4];
        exp_i = '{16'h1000, 16'h1002, 16'h1004, 16'h1006};
        rst = 1'b0; #1;
        tests++; if (imemEn !== 1'b1) begin fails++; $display("FAIL first_imemEn got %b want 1", imemEn); end
        tests++; if (imemAddr !== 16'h0000) begin fails++; $display("FAIL first_addr got %h want 0000", imemAddr); end
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL first_valid got %b want 0", instrValid); end
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            tests++; if (instr !== exp_i[i]) begin fails++; $display("FAIL fetch_instr%0d got %h want %h", i, instr, exp_i[i]); end
            tests++; if (nextPc !== exp_i[i] - 16'h0FFE) begin fails++; $display("FAIL fetch_nextPc%0d got %h want %h", i, nextPc, exp_i[i] - 16'h0FFE); end
            tests++; if (count !== 3'd1) begin fails++; $display("FAIL fetch_count%0d got %0d want 1", i, count); end
        end
        tests++; if (imemAddr !== 16'h0008) begin fails++; $display("FAIL fetch_addr got %h want 0008", imemAddr); end
    endtask

    task automatic test_stall();
        logic [2:0]  exp_c [6];
        logic        exp_e [6];
        logic [15:0] exp_i [5];
        exp_c = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        exp_e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_i = '{16'h1006, 16'h1008, 16'h100A, 16'h100C, 16'h100E};
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (count !== exp_c[i]) begin fails++; $display("FAIL stall_count%0d got %0d want %0d", i, count, exp_c[i]); end
            tests++; if (imemEn !== exp_e[i]) begin fails++; $display("FAIL stall_imemEn%0d got %b want %b", i, imemEn, exp_e[i]); end
            tests++; if (instr !== 16'h1006) begin fails++; $display("FAIL stall_instr%0d got %h want 1006", i, instr); end
            tick();
        end
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (instr !== exp_i[i]) begin fails++; $display("FAIL drain_instr%0d got %h want %h", i, instr, exp_i[i]); end
            tests++; if (count !== 3'd4) begin fails++; $display("FAIL drain_count%0d got %0d want 4", i, count); end
            tests++; if (imemEn !== 1'b1) begin fails++; $display("FAIL drain_imemEn%0d got %b want 1", i, imemEn); end
            tick();
        end
    endtask

    task automatic test_branch();
        doBranch = 1'b1; branchPc = 16'h0040; #1;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL br_full got %0d want 4", count); end
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL br_valid got %b want 0", instrValid); end
        tests++; if (imemEn !== 1'b0) begin fails++; $display("FAIL br_imemEn got %b want 0", imemEn); end
        tick(); doBranch = 1'b0; #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL br_count got %0d want 0", count); end
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL br_valid2 got %b want 0", instrValid); end
        tests++; if (instr !== 16'h0800) begin fails++; $display("FAIL br_instr got %h want 0800", instr); end
        tests++; if (imemAddr !== 16'h0040) begin fails++; $display("FAIL br_addr got %h want 0040", imemAddr); end
        tests++; if (nextPc !== 16'h0010) begin fails++; $display("FAIL br_nextPc_hold got %h want 0010", nextPc); end
        tick(); #1;
        tests++; if (instr !== 16'h1040) begin fails++; $display("FAIL br_instr2 got %h want 1040", instr); end
        tests++; if (nextPc !== 16'h0042) begin fails++; $display("FAIL br_nextPc got %h want 0042", nextPc); end
    endtask

    task automatic test_halt();
        logic [2:0] exp_c [3];
        exp_c = '{3'd2, 3'd1, 3'd0};
        stall = 1'b1;
        tick();
        stall = 1'b0; halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (count !== exp_c[i]) begin fails++; $display("FAIL halt_count%0d got %0d want %0d", i, count, exp_c[i]); end
            tests++; if (imemAddr !== 16'h0044) begin fails++; $display("FAIL halt_addr%0d got %h want 0044", i, imemAddr); end
            tests++; if (imemEn !== 1'b0) begin fails++; $display("FAIL halt_imemEn%0d got %b want 0", i, imemEn); end
            tick();
        end
        halt = 1'b0; #1;
        tests++; if (nextPc !== 16'h0044) begin fails++; $display("FAIL halt_nextPc got %h want 0044", nextPc); end
        tests++; if (imemEn !== 1'b1 || imemAddr !== 16'h0044) begin fails++; $display("FAIL halt_resume got %b/%h want 1/0044", imemEn, imemAddr); end
        tick(); #1;
        tests++; if (instr !== 16'h1044) begin fails++; $display("FAIL halt_instr got %h want 1044", instr); end
    endtask

    task automatic test_halt_detect();
        zero6 = 1'b1; doBranch = 1'b1; branchPc = 16'h0000;
        tick(); doBranch = 1'b0; #1;
        tests++; if (imemAddr !== 16'h0000) begin fails++; $display("FAIL hd_addr0 got %h want 0000", imemAddr); end
        tick(); tick(); tick(); tick(); #1;
        tests++; if (instr !== 16'h0000 || instrValid !== 1'b1) begin fails++; $display("FAIL hd_instr got %h/%b want 0000/1", instr, instrValid); end
        tests++; if (imemAddr !== 16'h0008) begin fails++; $display("FAIL hd_addr got %h want 0008", imemAddr); end
`ifdef FETCH_HALT_DETECT_EN
        tests++; if (imemEn !== 1'b0) begin fails++; $display("FAIL hd_imemEn got %b want 0", imemEn); end
        tick(); #1;
        tests++; if (instrValid !== 1'b0 || imemAddr !== 16'h0008) begin fails++; $display("FAIL hd_stopped got %b/%h want 0/0008", instrValid, imemAddr); end
`else
        tests++; if (imemEn !== 1'b1) begin fails++; $display("FAIL hd_imemEn got %b want 1", imemEn); end
        tick(); #1;
        tests++; if (instr !== 16'h1008 || imemAddr !== 16'h000A) begin fails++; $display("FAIL hd_cont got %h/%h want 1008/000a", instr, imemAddr); end
`endif
        doBranch = 1'b1; branchPc = 16'h0010;
        tick(); doBranch = 1'b0; zero6 = 1'b0; #1;
        tests++; if (imemAddr !== 16'h0010 || imemEn !== 1'b1) begin fails++; $display("FAIL hd_resume got %h/%b want 0010/1", imemAddr, imemEn); end
    endtask

    task automatic test_wrap_and_reset();
        doBranch = 1'b1; branchPc = 16'hFFFE;
        tick(); doBranch = 1'b0; #1;
        tests++; if (imemAddr !== 16'hFFFE) begin fails++; $display("FAIL wrap_addr0 got %h want fffe", imemAddr); end
        tick(); #1;
        tests++; if (instr !== 16'h0FFE) begin fails++; $display("FAIL wrap_instr got %h want 0ffe", instr); end
        tests++; if (nextPc !== 16'h0000) begin fails++; $display("FAIL wrap_nextPc got %h want 0000", nextPc); end
        tests++; if (imemAddr !== 16'h0000) begin fails++; $display("FAIL wrap_addr got %h want 0000", imemAddr); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL wrap_count got %0d want 1", count); end
        rst = 1'b1; #1;
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", instrValid); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL midrst_count got %0d want 0", count); end
        tests++; if (imemEn !== 1'b0) begin fails++; $display("FAIL midrst_imemEn got %b want 0", imemEn); end
        tests++; if (instr !== 16'h0800) begin fails++; $display("FAIL midrst_instr got %h want 0800", instr); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_halt();
        test_halt_detect();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
